// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: ALU op encodings, the legal-op check and FSM states.
package alu_arb_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b0001;
   localparam logic [3:0] OP_SLT  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b1101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } arb_state_e;

   function automatic logic op_is_legal(input logic [3:0] op);
      logic legal;
      case (op)
         OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
         OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: legal = 1'b1;
         default:                               legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus bundle between requesters, the arbiter and the shared ALU.
interface alu_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]    req_valid;
   logic [N_REQ-1:0]    req_ready;
   logic [4*N_REQ-1:0]  req_op;
   logic [32*N_REQ-1:0] req_rs1;
   logic [32*N_REQ-1:0] req_rs2;
   logic [N_REQ-1:0]    resp_valid;
   logic [N_REQ-1:0]    resp_ready;
   logic [31:0]         resp_data;
   logic                resp_err;
   logic [3:0]          alu_op;
   logic [31:0]         alu_rs1;
   logic [31:0]         alu_rs2;
   logic [31:0]         alu_rd;

   // Arbiter side
   modport slave (
      input  req_valid, req_op, req_rs1, req_rs2, resp_ready, alu_rd,
      output req_ready, resp_valid, resp_data, resp_err, alu_op, alu_rs1, alu_rs2
   );

   // Requester / ALU side
   modport master (
      output req_valid, req_op, req_rs1, req_rs2, resp_ready, alu_rd,
      input  req_ready, resp_valid, resp_data, resp_err, alu_op, alu_rs1, alu_rs2
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping mod N_REQ.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [PTR_W-1:0] grant_idx_o,
   output logic             grant_valid_o
);

   logic [N_REQ-1:0] hit;
   logic [PTR_W-1:0] idx [N_REQ];

   // idx[k] is the requester examined at priority position k (0 = highest)
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      logic [PTR_W:0] sum;
      assign sum     = {1'b0, ptr_i} + (PTR_W+1)'(gi);
      assign idx[gi] = (sum >= (PTR_W+1)'(N_REQ)) ? PTR_W'(sum - (PTR_W+1)'(N_REQ))
                                                   : PTR_W'(sum);
      assign hit[gi] = req_i[idx[gi]];
   end

   always_comb begin
      logic found;
      found       = 1'b0;
      grant_idx_o = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (hit[k]) begin
            found       = 1'b1;
            grant_idx_o = idx[k];
         end
      end
      grant_valid_o = found;
      grant_o       = '0;
      if (found) begin
         grant_o[grant_idx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU among N_REQ requesters, round-robin, one op in flight.
// Define ALU_ARB_PERF_EN to add saturating per-requester grant counters (perf_grant_cnt).
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int PTR_W = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   alu_arbiter_if.slave       bus
`ifdef ALU_ARB_PERF_EN
   ,
   output logic [16*N_REQ-1:0] perf_grant_cnt
`endif
);

   arb_state_e       state_q, state_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] owner_q;
   logic [3:0]       op_q;
   logic [31:0]      rs1_q, rs2_q;

   logic [N_REQ-1:0] grant;
   logic [PTR_W-1:0] grant_idx;
   logic             grant_valid;
   logic             accept;
   logic             op_legal;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr (
      .req_i         (bus.req_valid),
      .ptr_i         (ptr_q),
      .grant_o       (grant),
      .grant_idx_o   (grant_idx),
      .grant_valid_o (grant_valid)
   );

   assign accept   = (state_q == S_IDLE) && grant_valid;
   assign op_legal = op_is_legal(op_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (grant_valid) state_d = S_EXEC;
         S_EXEC:  state_d = S_RESP;
         S_RESP:  if (bus.resp_ready[owner_q]) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
   end

   // Issue registers feed the ALU directly, so alu_* only move on acceptance
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q   <= '0;
         owner_q <= '0;
         op_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
      end else begin
         ptr_q <= ptr_d;
         if (accept) begin
            owner_q <= grant_idx;
            op_q    <= bus.req_op[{grant_idx, 2'b00} +: 4];
            rs1_q   <= bus.req_rs1[{grant_idx, 5'b00000} +: 32];
            rs2_q   <= bus.req_rs2[{grant_idx, 5'b00000} +: 32];
         end
      end
   end

   assign bus.alu_op  = op_q;
   assign bus.alu_rs1 = rs1_q;
   assign bus.alu_rs2 = rs2_q;

   always_comb begin
      bus.req_ready  = '0;
      bus.resp_valid = '0;
      bus.resp_data  = '0;
      bus.resp_err   = 1'b0;
      unique case (state_q)
         S_IDLE: bus.req_ready = grant;
         S_RESP: begin
            bus.resp_valid[owner_q] = 1'b1;
            bus.resp_err            = ~op_legal;
            bus.resp_data           = op_legal ? bus.alu_rd : 32'h0;
         end
         default: ;
      endcase
   end

`ifdef ALU_ARB_PERF_EN
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_perf
      logic [15:0] cnt_q, cnt_d;

      always_comb begin
         cnt_d = cnt_q;
         if (accept && (grant_idx == PTR_W'(gi)) && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign perf_grant_cnt[16*gi +: 16] = cnt_q;
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter, checked against a transaction-level model.
module tb_alu_arbiter;

   localparam int N = 4;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   alu_arbiter_if #(.N_REQ(N)) bus ();

`ifdef ALU_ARB_PERF_EN
   logic [16*N-1:0] perf_grant_cnt;
`endif

   alu_arbiter #(
      .N_REQ (N),
      .PTR_W (2)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
`ifdef ALU_ARB_PERF_EN
      ,
      .perf_grant_cnt (perf_grant_cnt)
`endif
   );

   function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      case (op)
         4'b0000: return a + b;
         4'b1000: return a - b;
         4'b0001: return a << b[4:0];
         4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b0011: return (a < b) ? 32'd1 : 32'd0;
         4'b0100: return a ^ b;
         4'b0101: return a >> b[4:0];
         4'b1101: return 32'($signed(a) >>> b[4:0]);
         4'b0110: return a | b;
         4'b0111: return a & b;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   function automatic bit tb_legal(input logic [3:0] op);
      return op inside {4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                        4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
   endfunction

   function automatic int rr_pick(input int p, input logic [N-1:0] v);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   // Stand-in for the parent's ALU: result registered one cycle after its inputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) bus.alu_rd <= '0;
      else          bus.alu_rd <= alu_ref(bus.alu_op, bus.alu_rs1, bus.alu_rs2);
   end

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   bit          busy   = 1'b0;
   int          age    = 0;
   int          cur_owner = 0;
   logic [3:0]  cur_op;
   logic [31:0] cur_rs1, cur_rs2, exp_data;
   logic        exp_err;
   int          m_ptr  = 0;
   bit          drop_on_accept = 1'b1;
   logic [31:0] last_data [N];
   logic        last_err  [N];
   int          grant_log [$];
   int          accept_cyc [$];
   int          perf_cnt [N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
      bus.req_op[4*i +: 4]   = op;
      bus.req_rs1[32*i +: 32] = a;
      bus.req_rs2[32*i +: 32] = b;
      bus.req_valid[i]        = 1'b1;
   endtask

   // One clock: check outputs against the model, predict the edge, advance.
   task automatic cycle();
      logic [N-1:0] exp_ready, exp_rv, drop;
      int g;
      #1;
      exp_ready = '0;
      exp_rv    = '0;
      drop      = '0;
      g         = -1;
      if (!busy && bus.req_valid != '0) begin
         g = rr_pick(m_ptr, bus.req_valid);
         exp_ready[g] = 1'b1;
      end
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      if (busy) begin
         chk("alu_op", 32'(bus.alu_op), 32'(cur_op));
         chk("alu_rs1", bus.alu_rs1, cur_rs1);
         chk("alu_rs2", bus.alu_rs2, cur_rs2);
         if (age >= 2) begin
            exp_rv[cur_owner] = 1'b1;
            chk("resp_data", bus.resp_data, exp_data);
            chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
         end
      end
      chk("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));

      if (busy && age >= 2 && bus.resp_ready[cur_owner]) begin
         last_data[cur_owner] = exp_data;
         last_err[cur_owner]  = exp_err;
         $display("txn owner=%0d op=%b rs1=%h rs2=%h data=%h err=%0d",
                  cur_owner, cur_op, cur_rs1, cur_rs2, exp_data, exp_err);
         busy = 1'b0;
      end else if (busy) begin
         age++;
      end else if (g >= 0) begin
         busy      = 1'b1;
         age       = 1;
         cur_owner = g;
         cur_op    = bus.req_op[4*g +: 4];
         cur_rs1   = bus.req_rs1[32*g +: 32];
         cur_rs2   = bus.req_rs2[32*g +: 32];
         exp_err   = !tb_legal(cur_op);
         exp_data  = exp_err ? 32'h0 : alu_ref(cur_op, cur_rs1, cur_rs2);
         m_ptr     = (g + 1) % N;
         grant_log.push_back(g);
         accept_cyc.push_back(cyc);
         perf_cnt[g]++;
         if (drop_on_accept) drop[g] = 1'b1;
      end

      @(posedge clk);
      #1;
      cyc++;
      bus.req_valid = bus.req_valid & ~drop;
   endtask

   task automatic run_until_idle(input string tag, input int maxc);
      int n = 0;
      while ((busy || bus.req_valid != '0) && n < maxc) begin
         cycle();
         n++;
      end
      checks++;
      assert (n < maxc) else begin
         errors++;
         $error("FAIL %s timeout observed=%0d cycles expected<%0d", tag, n, maxc);
      end
   endtask

   task automatic do_reset();
      bus.req_valid = '0;
      reset_n       = 1'b0;
      busy          = 1'b0;
      m_ptr         = 0;
      foreach (perf_cnt[i]) perf_cnt[i] = 0;
      #1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
      chk("rst_resp_data", bus.resp_data, 32'h0);
      chk("rst_resp_err", 32'(bus.resp_err), 32'h0);
      chk("rst_alu_op", 32'(bus.alu_op), 32'h0);
      chk("rst_alu_rs1", bus.alu_rs1, 32'h0);
      chk("rst_alu_rs2", bus.alu_rs2, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_resp_valid_hold", 32'(bus.resp_valid), 32'h0);
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid  = '0;
      bus.req_op     = '0;
      bus.req_rs1    = '0;
      bus.req_rs2    = '0;
      bus.resp_ready = '1;
      foreach (last_data[i]) begin
         last_data[i] = '0;
         last_err[i]  = 1'b0;
         perf_cnt[i]  = 0;
      end
      #2;
      do_reset();

      // Single ADD from requester 0
      set_req(0, 4'b0000, 32'd5, 32'd7);
      run_until_idle("add", 20);
      chk("add_data", last_data[0], 32'd12);
      chk("add_err", 32'(last_err[0]), 32'h0);

      // All requesters held: strict rotation, 3 cycles per op
      do_reset();
      drop_on_accept = 1'b0;
      grant_log.delete();
      accept_cyc.delete();
      for (int i = 0; i < N; i++) set_req(i, 4'($urandom_range(0, 7)), $urandom, $urandom);
      for (int n = 0; n < 40 && grant_log.size() < 5; n++) cycle();
      bus.req_valid  = '0;
      drop_on_accept = 1'b1;
      run_until_idle("rotate_drain", 20);
      chk("rotate_count", 32'(grant_log.size()), 32'd5);
      if (grant_log.size() == 5) begin
         for (int k = 0; k < 5; k++) chk($sformatf("rotate_grant%0d", k), 32'(grant_log[k]), 32'(k % N));
         for (int k = 0; k < 4; k++)
            chk($sformatf("rotate_gap%0d", k), 32'(accept_cyc[k+1] - accept_cyc[k]), 32'd3);
      end

      // SRA with response back-pressure; other resp_ready bits high and another request waiting
      set_req(2, 4'b1101, 32'h8000_0000, 32'd4);
      bus.resp_ready = 4'b1011;
      for (int n = 0; n < 10 && !(busy && age >= 2); n++) cycle();
      chk("sra_resp_reached", 32'(busy && age >= 2), 32'h1);
      set_req(0, 4'b0000, 32'd1, 32'd1);
      repeat (5) cycle();
      chk("sra_still_busy", 32'(busy), 32'h1);
      bus.resp_ready = '1;
      run_until_idle("sra", 20);
      chk("sra_data", last_data[2], 32'hF800_0000);
      chk("sra_err", 32'(last_err[2]), 32'h0);

      // Illegal op then SUB on requester 1
      set_req(1, 4'b1111, 32'h1234_5678, 32'h0000_0042);
      run_until_idle("illegal", 20);
      chk("illegal_data", last_data[1], 32'h0);
      chk("illegal_err", 32'(last_err[1]), 32'h1);
      set_req(1, 4'b1000, 32'd3, 32'd5);
      run_until_idle("sub", 20);
      chk("sub_data", last_data[1], 32'hFFFF_FFFE);
      chk("sub_err", 32'(last_err[1]), 32'h0);

      // Reset while requester 2's op is in EXEC; the next grant must restart at 0
      set_req(2, 4'b0110, 32'hF0F0_0000, 32'h0000_0F0F);
      for (int n = 0; n < 10 && !busy; n++) cycle();
      chk("midrst_in_exec", 32'(busy && age == 1), 32'h1);
      do_reset();
      grant_log.delete();
      for (int i = 0; i < N; i++) set_req(i, 4'b0100, $urandom, $urandom);
      cycle();
      chk("midrst_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);
      run_until_idle("midrst_drain", 40);

      // Randomized traffic with random back-pressure and occasional early drops
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < N; i++) begin
            if (bus.req_valid[i]) begin
               if ($urandom_range(0, 19) == 0) bus.req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 9) < 4) begin
               set_req(i, 4'($urandom_range(0, 15)), $urandom, $urandom);
            end
         end
         bus.resp_ready = 4'($urandom);
         cycle();
      end
      bus.req_valid  = '0;
      bus.resp_ready = '1;
      run_until_idle("random_drain", 20);

`ifdef ALU_ARB_PERF_EN
      for (int i = 0; i < N; i++)
         chk($sformatf("perf_random%0d", i), 32'(perf_grant_cnt[16*i +: 16]), 32'(perf_cnt[i]));
      do_reset();
      for (int k = 0; k < 3; k++) begin
         set_req(3, 4'b0000, 32'(k), 32'd1);
         run_until_idle("perf_req3", 20);
      end
      for (int i = 0; i < N; i++)
         chk($sformatf("perf_req3_cnt%0d", i), 32'(perf_grant_cnt[16*i +: 16]), (i == 3) ? 32'd3 : 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
